// File: rtl/bot_update_arbiter.sv
// Round-robin arbiter that shares one state-update channel among N_BOTS bots.
// A granted record is latched and held downstream under a valid/ready handshake.
// Each bot also has a watchdog that flags it stale when it goes TIMEOUT cycles
// without an acknowledge.
module bot_update_arbiter #(
    parameter int unsigned N_BOTS  = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1000,
    localparam int unsigned ID_W   = (N_BOTS > 1) ? $clog2(N_BOTS) : 1,
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1),
    localparam int unsigned REC_W  = 4 * DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_BOTS-1:0]          req,
    input  logic [N_BOTS*REC_W-1:0]    bot_data,
    output logic [N_BOTS-1:0]          ack,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ID_W-1:0]            out_bot_id,
    output logic [DATA_W-1:0]          out_vx,
    output logic [DATA_W-1:0]          out_vy,
    output logic [DATA_W-1:0]          out_x,
    output logic [DATA_W-1:0]          out_y,
    output logic [N_BOTS-1:0]          stale,
    output logic                       busy
);

    typedef enum logic [0:0] {StIdle, StOut} state_e;

    state_e                   state_q, state_d;
    logic [N_BOTS-1:0]        ack_q, ack_d;
    logic [ID_W-1:0]          last_q, last_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic [REC_W-1:0]         rec_q, rec_d;
    logic [CNT_W-1:0]         cnt_q [N_BOTS];
    logic [CNT_W-1:0]         cnt_d [N_BOTS];
    logic [N_BOTS-1:0]        stale_q, stale_d;

    logic [ID_W-1:0]          grant_id;
    logic [N_BOTS*REC_W-1:0]  data_shift;
    logic [REC_W-1:0]         grant_rec;

    // First requesting bot strictly after 'last', wrapping round.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_BOTS-1:0] r,
                                                input logic [ID_W-1:0]   last);
        logic [ID_W-1:0]   pick;
        logic              found;
        int unsigned       idx;
        logic [N_BOTS-1:0] r_shift;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_BOTS; k++) begin
            idx     = (32'(last) + k) % N_BOTS;
            r_shift = r >> idx;
            if (!found && r_shift[0]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    // Candidate grant and its record, evaluated every cycle.
    always_comb begin
        grant_id   = rr_pick(req, last_q);
        data_shift = bot_data >> (32'(grant_id) * REC_W);
        grant_rec  = data_shift[REC_W-1:0];
    end

    // FSM next-state: grant in IDLE, wait for the downstream handshake in OUT.
    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        last_d  = last_q;
        id_d    = id_q;
        rec_d   = rec_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StOut;
                    ack_d   = N_BOTS'(1) << grant_id;
                    last_d  = grant_id;
                    id_d    = grant_id;
                    rec_d   = grant_rec;
                end
            end
            StOut: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Watchdog next-state: an ack clears the counter (and stale) on the following edge.
    always_comb begin
        for (int unsigned i = 0; i < N_BOTS; i++) begin
            if (ack_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_W'(TIMEOUT)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            stale_d[i] = (cnt_d[i] == CNT_W'(TIMEOUT));
        end
    end

    // State registers; last grant resets to the top bot so bot 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ack_q   <= '0;
            last_q  <= ID_W'(N_BOTS - 1);
            id_q    <= '0;
            rec_q   <= '0;
            stale_q <= '0;
            for (int unsigned i = 0; i < N_BOTS; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
            id_q    <= id_d;
            rec_q   <= rec_d;
            stale_q <= stale_d;
            for (int unsigned i = 0; i < N_BOTS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Output mapping; record order is {vx, vy, x, y} with vx in the MSBs.
    always_comb begin
        ack        = ack_q;
        out_valid  = (state_q == StOut);
        busy       = (state_q == StOut);
        out_bot_id = id_q;
        out_vx     = rec_q[4*DATA_W-1 -: DATA_W];
        out_vy     = rec_q[3*DATA_W-1 -: DATA_W];
        out_x      = rec_q[2*DATA_W-1 -: DATA_W];
        out_y      = rec_q[DATA_W-1:0];
        stale      = stale_q;
    end

endmodule

// File: tb/tb_bot_update_arbiter.sv
// Scoreboard bench for bot_update_arbiter: stimulus pushes the expected grant
// order, a monitor pops and checks each record as its ack appears.
module tb_bot_update_arbiter;

    localparam int unsigned N_BOTS  = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned REC_W   = 4 * DATA_W;
    localparam int unsigned ID_W    = 2;

    logic                      clk;
    logic                      rst;
    logic [N_BOTS-1:0]         req;
    logic [N_BOTS*REC_W-1:0]   bot_data;
    logic [N_BOTS-1:0]         ack;
    logic                      out_valid;
    logic                      out_ready;
    logic [ID_W-1:0]           out_bot_id;
    logic [DATA_W-1:0]         out_vx, out_vy, out_x, out_y;
    logic [N_BOTS-1:0]         stale;
    logic                      busy;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    logic [REC_W-1:0] rec_tab [N_BOTS];

    bot_update_arbiter #(
        .N_BOTS  (N_BOTS),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .bot_data   (bot_data),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bot_id (out_bot_id),
        .out_vx     (out_vx),
        .out_vy     (out_vy),
        .out_x      (out_x),
        .out_y      (out_y),
        .stale      (stale),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [REC_W-1:0] act,
                       input logic [REC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bots drop req once they see their ack.
    task automatic cyc();
        @(posedge clk);
        #2;
        req = req & ~ack;
    endtask

    // Monitor: every ack pulse presents a new record; compare with the next expected grant.
    always @(posedge clk) begin
        int e;
        logic [N_BOTS-1:0] oh;
        #1;
        if (!rst && ack != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", REC_W'(ack), '0);
            end else begin
                e  = exp_q.pop_front();
                oh = N_BOTS'(1) << e;
                chk("mon_ack", REC_W'(ack), REC_W'(oh));
                chk("mon_valid", REC_W'(out_valid), 1);
                chk("mon_id", REC_W'(out_bot_id), REC_W'(e));
                chk("mon_rec", {out_vx, out_vy, out_x, out_y}, rec_tab[e]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N_BOTS-1:0] seq_ack [6];
        rec_tab[0] = {32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        rec_tab[1] = {32'h0001_8000, 32'hFFFF_C000, 32'h000A_0000, 32'h0014_0000};
        rec_tab[2] = {32'hFFFF_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        bot_data  = {rec_tab[2], rec_tab[1], rec_tab[0]};
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", REC_W'(out_valid), 0);
        chk("rst_ack", REC_W'(ack), 0);
        chk("rst_id", REC_W'(out_bot_id), 0);
        chk("rst_rec", {out_vx, out_vy, out_x, out_y}, '0);
        chk("rst_stale", REC_W'(stale), 0);
        chk("rst_busy", REC_W'(busy), 0);
        rst = 1'b0;

        // Watchdog: nobody requests, stale rises on the 8th edge.
        repeat (7) cyc();
        chk("stale_pre", REC_W'(stale), 0);
        cyc();
        chk("stale_rise", REC_W'(stale), 3'b111);
        chk("idle_valid", REC_W'(out_valid), 0);

        // All three request: grants 0,1,2 two cycles apart.
        req = 3'b111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        seq_ack = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("rr111_ack%0d", i), REC_W'(ack), REC_W'(seq_ack[i]));
            chk($sformatf("rr111_valid%0d", i), REC_W'(out_valid), REC_W'(seq_ack[i] != 0));
            if (i == 4) chk("stale2_at_ack", REC_W'(stale[2]), 1);
            if (i == 5) chk("stale2_cleared", REC_W'(stale[2]), 0);
        end

        // Single bot 1 request.
        req = 3'b010;
        exp_q.push_back(1);
        cyc();
        chk("b1_ack", REC_W'(ack), 3'b010);
        chk("b1_busy", REC_W'(busy), 1);
        chk("b1_id", REC_W'(out_bot_id), 1);
        cyc();
        chk("b1_valid_drop", REC_W'(out_valid), 0);
        chk("b1_busy_drop", REC_W'(busy), 0);

        // After bot 1: 101 grants 2 then 0.
        req = 3'b101;
        exp_q.push_back(2); exp_q.push_back(0);
        seq_ack[0:3] = '{3'b100, 3'b000, 3'b001, 3'b000};
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("rr101_ack%0d", i), REC_W'(ack), REC_W'(seq_ack[i]));
        end

        // Backpressure: bot 0 held 10 cycles while bot 1 waits.
        out_ready = 1'b0;
        req       = 3'b001;
        exp_q.push_back(0);
        cyc();
        chk("bp_ack0", REC_W'(ack), 3'b001);
        req[1] = 1'b1;
        exp_q.push_back(1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("bp_valid%0d", i), REC_W'(out_valid), 1);
            chk($sformatf("bp_ack%0d", i), REC_W'(ack), 0);
            chk($sformatf("bp_id%0d", i), REC_W'(out_bot_id), 0);
            chk($sformatf("bp_rec%0d", i), {out_vx, out_vy, out_x, out_y}, rec_tab[0]);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_release_valid", REC_W'(out_valid), 0);
        chk("bp_release_ack", REC_W'(ack), 0);
        cyc();
        chk("bp_b1_ack", REC_W'(ack), 3'b010);
        chk("bp_b1_id", REC_W'(out_bot_id), 1);
        cyc();

        // Reset during OUT with backpressure.
        out_ready = 1'b0;
        req       = 3'b100;
        exp_q.push_back(2);
        cyc();
        chk("mid_ack2", REC_W'(ack), 3'b100);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", REC_W'(out_valid), 0);
        chk("mid_rst_ack", REC_W'(ack), 0);
        chk("mid_rst_busy", REC_W'(busy), 0);
        chk("mid_rst_stale", REC_W'(stale), 0);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        req       = 3'b111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        seq_ack = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("post_rst_ack%0d", i), REC_W'(ack), REC_W'(seq_ack[i]));
        end

        repeat (2) cyc();
        chk("scoreboard_drained", REC_W'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bot_update_arbiter.md
Name: bot_update_arbiter

Overview:
- Synthesizable scheduler that shares one state-update channel among N_BOTS bot interfaces.
- Each bot posts a velocity/position record (vx, vy, x, y) and raises a request, which is the "written" flag.
- Arbiter grants round-robin, latches the record, pulses an acknowledge back to the bot (the "read" flag), and presents the record downstream with a valid/ready handshake.
- Per-bot watchdog flags bots that have not delivered an update within TIMEOUT cycles.

Parameters:
- N_BOTS, 3, number of requesting bots (2..16)
- DATA_W, 32, width of each field (signed Q16.16 fixed point; arbiter does not interpret it)
- TIMEOUT, 1000, cycles without an ack before stale[i] is set (≥2)
- Derived localparams: ID_W = max(1, clog2(N_BOTS)); CNT_W = clog2(TIMEOUT+1)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_BOTS  level request per bot; bit i high = bot i has a fresh record
- bot_data  in  N_BOTS*4*DATA_W  flattened records; bot i at [i*4*DATA_W +: 4*DATA_W], order {vx,vy,x,y}, vx in MSBs
- ack  out  N_BOTS  one-cycle pulse to the granted bot
- out_valid  out  1  downstream record valid
- out_ready  in  1  downstream accepts
- out_bot_id  out  ID_W  index of the bot owning the current record
- out_vx, out_vy, out_x, out_y  out  DATA_W each  latched record fields
- stale  out  N_BOTS  watchdog flag per bot
- busy  out  1  high while state is OUT

Behaviour:
- Reset (async, immediate):
  - state=IDLE; ack=0; out_valid=0; out_bot_id=0; out fields=0; stale=0; busy=0
  - watchdog counters=0
  - last_grant=N_BOTS-1, so bot 0 has first priority
- FSM has two states, IDLE and OUT.
- IDLE:
  - If req≠0 at a rising edge, select g = first set bit searching from (last_grant+1) mod N_BOTS upward with wrap.
  - At that same edge: latch bot g's record into out fields; out_bot_id=g; out_valid=1; ack[g]=1; last_grant=g; state→OUT.
  - If req=0, stay in IDLE with all outputs held.
- OUT:
  - ack deasserts after exactly one cycle.
  - Record and out_bot_id are held stable while out_valid=1.
  - On an edge with out_valid&out_ready: out_valid=0, state→IDLE.
  - req is not sampled in OUT.
- Latency and throughput:
  - req high → ack and out_valid high one edge later.
  - Maximum rate is one grant every 2 cycles (out_ready tied high).
- Requester rule:
  - A bot must drop req in the cycle after it sees ack.
  - A req still high when the arbiter returns to IDLE is treated as a new request.
- Simultaneous requests: exactly one grant per IDLE decision. Round-robin guarantees each requesting bot is granted within N_BOTS grants.
- Backpressure: out_ready low holds OUT indefinitely; no new acks are issued; requests wait.
- Watchdog, per bot i:
  - Counter clears to 0 on the edge after ack[i]=1; otherwise increments, saturating at TIMEOUT.
  - stale[i] = (count_i == TIMEOUT), registered.
  - stale[i] clears together with its counter.
  - ack and stale for the same bot in the same cycle: clear wins.
- Reset asserted mid-OUT: record is discarded, out_valid drops immediately, ack drops, pointer returns to bot 0 priority.
- No arithmetic on data; fields pass through bit-exact.

Test Plan:
- Reset, then req=3'b010 with bot1 record {1.5,-0.25,10.0,20.0} (0x00018000, 0xFFFFC000, 0x000A0000, 0x00140000), out_ready=1 → next cycle ack=3'b010, out_valid=1, out_bot_id=1, fields bit-exact; out_valid low one cycle later.
- req=3'b111 held (each bot drops its req after its ack), out_ready=1 → grants in order 0,1,2 on cycles 1,3,5; exactly one ack bit per pulse.
- After bot 1 is granted, req=3'b101 → bot 2 granted first, then bot 0 two cycles later.
- out_ready=0 for 10 cycles after a grant to bot 0 while req[1]=1 → out_valid and fields stable; ack stays 0; bot 1 granted on the second edge after out_ready rises.
- TIMEOUT=8, bot 2 never requests → stale[2] rises 8 cycles after reset and holds; a bot 2 grant clears stale[2] the edge after ack[2].
- Assert rst during OUT with out_ready=0 → out_valid, ack, busy, stale all 0 at once; after release, req=3'b111 grants bot 0 first.
